// File: rtl/dram_arbiter.sv
// Two-port round-robin DRAM arbiter: the core and the loader share one DRAM.
// Each access holds one strobe for ACC_CYCLES cycles and then pulses done.
module dram_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  output logic        core_gnt,
  output logic        core_done,
  output logic [7:0]  core_rdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic [7:0]  ld_rdata,
  output logic [15:0] dram_addr,
  output logic [7:0]  dram_wdata,
  output logic        dram_read,
  output logic        dram_write,
  input  logic [7:0]  dram_rdata,
  output logic        busy,
  output logic [7:0]  core_cnt,
  output logic [7:0]  ld_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        win_ld_r, win_ld_s;
  logic        last_ld_r, last_ld_s;
  logic        we_r, we_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        core_gnt_r, core_gnt_s, ld_gnt_r, ld_gnt_s;
  logic        core_done_r, core_done_s, ld_done_r, ld_done_s;
  logic        rd_r, rd_s, wr_r, wr_s, busy_r, busy_s;
  logic [7:0]  core_rdata_r, core_rdata_s, ld_rdata_r, ld_rdata_s;
  logic [7:0]  core_cnt_r, core_cnt_s, ld_cnt_r, ld_cnt_s;
  logic        pick_ld_s, sel_we_s;

  // Loader wins when it asks alone, or on a tie when the core won last time
  assign pick_ld_s = ld_req & (~core_req | ~last_ld_r);
  assign sel_we_s  = pick_ld_s ? ld_we : core_we;

  // Next-state and next-output decode
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    win_ld_s     = win_ld_r;
    last_ld_s    = last_ld_r;
    we_s         = we_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    core_gnt_s   = 1'b0;
    ld_gnt_s     = 1'b0;
    core_done_s  = 1'b0;
    ld_done_s    = 1'b0;
    rd_s         = 1'b0;
    wr_s         = 1'b0;
    core_rdata_s = core_rdata_r;
    ld_rdata_s   = ld_rdata_r;
    core_cnt_s   = core_cnt_r;
    ld_cnt_s     = ld_cnt_r;
    case (state_r)
      IDLE: begin
        if (core_req | ld_req) begin
          state_s    = ACCESS;
          cnt_s      = 4'd0;
          win_ld_s   = pick_ld_s;
          we_s       = sel_we_s;
          addr_s     = pick_ld_s ? ld_addr : core_addr;
          wdata_s    = pick_ld_s ? ld_wdata : core_wdata;
          core_gnt_s = ~pick_ld_s;
          ld_gnt_s   = pick_ld_s;
          rd_s       = ~sel_we_s;
          wr_s       = sel_we_s;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        cnt_s = cnt_r + 4'd1;
        if (cnt_r == LAST_CNT) begin
          state_s      = DONE;
          core_done_s  = ~win_ld_r;
          ld_done_s    = win_ld_r;
          core_rdata_s = (~we_r & ~win_ld_r) ? dram_rdata : core_rdata_r;
          ld_rdata_s   = (~we_r & win_ld_r) ? dram_rdata : ld_rdata_r;
        end else begin
          core_gnt_s = ~win_ld_r;
          ld_gnt_s   = win_ld_r;
          rd_s       = ~we_r;
          wr_s       = we_r;
        end
      end
      DONE: begin
        state_s   = IDLE;
        last_ld_s = win_ld_r;
        if (win_ld_r) begin
          ld_cnt_s = sat_inc(ld_cnt_r);
        end else begin
          core_cnt_s = sat_inc(core_cnt_r);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset leaves the loader as last winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      win_ld_r     <= 1'b0;
      last_ld_r    <= 1'b1;
      we_r         <= 1'b0;
      addr_r       <= 16'd0;
      wdata_r      <= 8'd0;
      core_gnt_r   <= 1'b0;
      ld_gnt_r     <= 1'b0;
      core_done_r  <= 1'b0;
      ld_done_r    <= 1'b0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      busy_r       <= 1'b0;
      core_rdata_r <= 8'd0;
      ld_rdata_r   <= 8'd0;
      core_cnt_r   <= 8'd0;
      ld_cnt_r     <= 8'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      win_ld_r     <= win_ld_s;
      last_ld_r    <= last_ld_s;
      we_r         <= we_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      core_gnt_r   <= core_gnt_s;
      ld_gnt_r     <= ld_gnt_s;
      core_done_r  <= core_done_s;
      ld_done_r    <= ld_done_s;
      rd_r         <= rd_s;
      wr_r         <= wr_s;
      busy_r       <= busy_s;
      core_rdata_r <= core_rdata_s;
      ld_rdata_r   <= ld_rdata_s;
      core_cnt_r   <= core_cnt_s;
      ld_cnt_r     <= ld_cnt_s;
    end
  end

  assign core_gnt   = core_gnt_r;
  assign ld_gnt     = ld_gnt_r;
  assign core_done  = core_done_r;
  assign ld_done    = ld_done_r;
  assign core_rdata = core_rdata_r;
  assign ld_rdata   = ld_rdata_r;
  assign dram_addr  = addr_r;
  assign dram_wdata = wdata_r;
  assign dram_read  = rd_r;
  assign dram_write = wr_r;
  assign busy       = busy_r;
  assign core_cnt   = core_cnt_r;
  assign ld_cnt     = ld_cnt_r;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a transaction-timeline model checks instance 0
// (ACC_CYCLES=2) every cycle; instances 1 and 2 cover ACC_CYCLES=1 and 15.
module tb_dram_arbiter;
  localparam int ACC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, core_req = 1'b0, core_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] core_addr = 16'd0, ld_addr = 16'd0;
  logic [7:0]  core_wdata = 8'd0, ld_wdata = 8'd0, dram_rdata = 8'd0;
  logic [2:0]  core_gnt, core_done, ld_gnt, ld_done, dram_read, dram_write, busy;
  logic [2:0][7:0]  core_rdata, ld_rdata, dram_wdata, core_cnt, ld_cnt;
  logic [2:0][15:0] dram_addr;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dram_arbiter #(.ACC_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt[g]), .core_done(core_done[g]), .core_rdata(core_rdata[g]),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt[g]), .ld_done(ld_done[g]), .ld_rdata(ld_rdata[g]),
      .dram_addr(dram_addr[g]), .dram_wdata(dram_wdata[g]),
      .dram_read(dram_read[g]), .dram_write(dram_write[g]), .dram_rdata(dram_rdata),
      .busy(busy[g]), .core_cnt(core_cnt[g]), .ld_cnt(ld_cnt[g])
    );
  end

  int checks = 0, passed = 0, fails = 0;

  // Reference: one transaction at a time, described by the edge it was sampled on
  int          e = 0, e0 = 0;
  bit          m_act = 1'b0, m_win = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [15:0] m_addr = 16'd0;
  logic [7:0]  m_wdata = 8'd0;
  logic [7:0]  m_rdata [2];
  logic [7:0]  m_cnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    e++;
    if (!rst_n) begin
      m_act = 1'b0; m_last = 1'b1; m_addr = 16'd0; m_wdata = 8'd0;
      m_rdata[0] = 8'd0; m_rdata[1] = 8'd0; m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
    end else if (m_act) begin
      if (e - e0 == ACC && !m_we) m_rdata[m_win] = dram_rdata;
      if (e - e0 == ACC + 1) begin
        if (m_cnt[m_win] != 8'hFF) m_cnt[m_win] = m_cnt[m_win] + 8'd1;
        m_last = m_win;
        m_act  = 1'b0;
      end
    end else if (core_req || ld_req) begin
      m_win   = (core_req && ld_req) ? !m_last : ld_req;
      m_we    = m_win ? ld_we : core_we;
      m_addr  = m_win ? ld_addr : core_addr;
      m_wdata = m_win ? ld_wdata : core_wdata;
      m_act   = 1'b1;
      e0      = e;
    end
  endtask

  task automatic check_cycle();
    logic g, d;
    g = m_act && (e - e0 < ACC);
    d = m_act && (e - e0 == ACC);
    chk("cycle", {1'b0, core_gnt[0], ld_gnt[0], core_done[0], ld_done[0], dram_read[0],
                  dram_write[0], busy[0], dram_addr[0], dram_wdata[0], core_rdata[0],
                  ld_rdata[0], core_cnt[0], ld_cnt[0]},
                 {1'b0, g && !m_win, g && m_win, d && !m_win, d && m_win, g && !m_we,
                  g && m_we, m_act, m_addr, m_wdata, m_rdata[0], m_rdata[1], m_cnt[0], m_cnt[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; core_req = 1'b0; ld_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    int q_order [$];
    int ord_code, last_rise, spacing_bad, w1, w15, l1, l15;
    bit pc, pl;

    // Reset state
    do_reset();
    chk("reset_idle", 64'({busy[0], core_gnt[0], ld_gnt[0], core_cnt[0]}), 64'd0);

    // Core read of 0x0040 returning 0xA5
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0040; dram_rdata = 8'hA5;
    step();
    core_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("core_read_data", 64'(core_rdata[0]), 64'h00A5);
    chk("core_read_cnt", 64'(core_cnt[0]), 64'd1);

    // Loader write of 0x3C to 0x1234
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h1234; ld_wdata = 8'h3C;
    step();
    ld_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ld_write_cnt", 64'(ld_cnt[0]), 64'd1);
    chk("ld_write_rdata_kept", 64'(ld_rdata[0]), 64'd0);

    // Simultaneous requests for exactly four accesses
    do_reset();
    core_req = 1'b1; ld_req = 1'b1; core_we = 1'b0; ld_we = 1'b1;
    pc = 1'b0; pl = 1'b0; ord_code = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (core_gnt[0] && !pc) q_order.push_back(0);
      if (ld_gnt[0] && !pl) q_order.push_back(1);
      pc = core_gnt[0]; pl = ld_gnt[0];
      if (i == 15) begin core_req = 1'b0; ld_req = 1'b0; end
    end
    foreach (q_order[k]) ord_code = ord_code * 2 + q_order[k];
    chk("grant_order", 64'({q_order.size(), ord_code}), 64'({32'd4, 32'd5}));
    chk("tie_counts", 64'({core_cnt[0], ld_cnt[0]}), 64'({8'd2, 8'd2}));

    // Reset in the second ACCESS cycle of a read
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0777;
    step();
    core_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_reset_quiet", 64'({dram_read[0], busy[0], core_done[0]}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    core_req = 1'b1;
    step();
    core_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("after_reset_cnt", 64'(core_cnt[0]), 64'd1);

    // 300 back-to-back accesses from one requester: saturation and spacing
    do_reset();
    core_req = 1'b1; last_rise = -1; spacing_bad = 0; pc = 1'b0;
    for (int i = 0; i < 1210; i++) begin
      core_we = 1'($urandom_range(0, 1)); core_addr = 16'($urandom);
      core_wdata = 8'($urandom); dram_rdata = 8'($urandom);
      step();
      if (core_gnt[0] && !pc) begin
        if (last_rise >= 0 && i - last_rise != ACC + 2) spacing_bad++;
        last_rise = i;
      end
      pc = core_gnt[0];
    end
    core_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("cnt_saturated", 64'(core_cnt[0]), 64'h00FF);
    chk("grant_spacing", 64'(spacing_bad), 64'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      core_req = 1'($urandom_range(0, 1)); ld_req = 1'($urandom_range(0, 1));
      core_we = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
      core_addr = 16'($urandom); ld_addr = 16'($urandom);
      core_wdata = 8'($urandom); ld_wdata = 8'($urandom); dram_rdata = 8'($urandom);
      step();
    end

    // Strobe width and done latency for ACC_CYCLES = 1 and 15
    do_reset();
    core_req = 1'b1; core_we = 1'b0; ld_req = 1'b0;
    w1 = 0; w15 = 0; l1 = 0; l15 = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (i == 0) core_req = 1'b0;
      if (dram_read[1]) w1++;
      if (dram_read[2]) w15++;
      if (core_done[1] && l1 == 0) l1 = i + 1;
      if (core_done[2] && l15 == 0) l15 = i + 1;
    end
    chk("acc1_width", 64'(w1), 64'd1);
    chk("acc15_width", 64'(w15), 64'd15);
    chk("acc1_latency", 64'(l1), 64'd2);
    chk("acc15_latency", 64'(l15), 64'd16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
